// File: rtl/puf_uart_pkg.sv
// PUF UART byte-protocol definitions shared by the host initiator and the
// device-side UART controller: widths, frame length and FSM state encoding.
package puf_uart_pkg;

    localparam int RESP_BYTES_DEF = 32;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = RESP_BYTES_DEF * BYTE_W;
    localparam int STATE_W        = 4;

    localparam logic [STATE_W-1:0] ST_IDLE       = 4'd0;
    localparam logic [STATE_W-1:0] ST_SEND_CH    = 4'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_TX    = 4'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_ECHO  = 4'd3;
    localparam logic [STATE_W-1:0] ST_RECV_R     = 4'd4;
    localparam logic [STATE_W-1:0] ST_WAIT_ECHO2 = 4'd5;
    localparam logic [STATE_W-1:0] ST_RECV_S     = 4'd6;
    localparam logic [STATE_W-1:0] ST_FINISH     = 4'd7;
    localparam logic [STATE_W-1:0] ST_ERR_ECHO   = 4'd8;
    localparam logic [STATE_W-1:0] ST_ERR_TO     = 4'd9;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE       = ST_IDLE,
        S_SEND_CH    = ST_SEND_CH,
        S_WAIT_TX    = ST_WAIT_TX,
        S_WAIT_ECHO  = ST_WAIT_ECHO,
        S_RECV_R     = ST_RECV_R,
        S_WAIT_ECHO2 = ST_WAIT_ECHO2,
        S_RECV_S     = ST_RECV_S,
        S_FINISH     = ST_FINISH,
        S_ERR_ECHO   = ST_ERR_ECHO,
        S_ERR_TO     = ST_ERR_TO
    } puf_state_e;

    // States in which the initiator is waiting on the UART and the timeout runs.
    function automatic logic is_wait_state(input puf_state_e s);
        return (s == S_WAIT_TX) || (s == S_WAIT_ECHO) || (s == S_RECV_R) ||
               (s == S_WAIT_ECHO2) || (s == S_RECV_S);
    endfunction

endpackage

// File: rtl/puf_rx_timeout.sv
// Idle-wait watchdog: restarts on clear_i, counts while en_i, flags expire_o
// so that the abort state is entered LIMIT cycles after the last restart.
module puf_rx_timeout #(
    parameter int TO_W  = 20,
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // The restart cycle itself counts as the first elapsed cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = TO_W'(1);
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q >= LAST);

endmodule

// File: rtl/puf_challenge_initiator.sv
// Host-side PUF challenge initiator: sends one challenge byte, checks the echo and
// assembles the 32-byte reply. Define PUF_SECOND_RESP_EN for a second echoed word.
module puf_challenge_initiator
    import puf_uart_pkg::*;
#(
    parameter int RESP_BYTES     = RESP_BYTES_DEF,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [BYTE_W-1:0]              challenge_in,
    output logic [BYTE_W-1:0]              tx_byte,
    output logic                           tx_DV,
    input  logic                           uart_done,
    input  logic [BYTE_W-1:0]              rx_byte,
    input  logic                           rx_DV,
    output logic [RESP_BYTES*BYTE_W-1:0]   response,
    output logic                           response_DV,
    output logic [RESP_BYTES*BYTE_W-1:0]   second,
    output logic                           second_DV,
    output logic                           busy,
    output logic                           done,
    output logic                           err_echo,
    output logic                           err_timeout,
    output logic [STATE_W-1:0]             dbg_state_o
);

    // All byte traffic uses single-cycle strobes with no back-pressure: tx_DV and
    // rx_DV qualify their byte for exactly one clock, and uart_done marks the end
    // of the TX byte. Strobes arriving in a state that does not expect them are dropped.

    localparam int RESP_W = RESP_BYTES * BYTE_W;
    localparam int CNT_W  = $clog2(RESP_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(RESP_BYTES - 1);

    puf_state_e                state_q, state_d;
    logic [BYTE_W-1:0]         chal_q;
    logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [RESP_W-BYTE_W-1:0]  shift_q;
    logic [RESP_W-1:0]         response_q;
    logic                      shift_en, load_resp;
    logic                      to_clear, to_expire, in_wait, echo_ok, rx_last;
`ifdef PUF_SECOND_RESP_EN
    logic [RESP_W-1:0]         first_q, second_q;
    logic                      cap_first;
`endif

    assign in_wait = is_wait_state(state_q);
    assign echo_ok = (rx_byte == chal_q);
    assign rx_last = (byte_cnt_q == LAST_BYTE);

    puf_rx_timeout #(
        .TO_W  (TO_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (to_clear),
        .en_i     (in_wait),
        .expire_o (to_expire)
    );

    // An accepted event always beats a coincident timeout expiry.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_en   = 1'b0;
        load_resp  = 1'b0;
        to_clear   = !in_wait;
`ifdef PUF_SECOND_RESP_EN
        cap_first  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SEND_CH;
            end
            S_SEND_CH: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (uart_done) begin
                    to_clear = 1'b1;
                    state_d  = S_WAIT_ECHO;
                end else if (to_expire) begin
                    state_d = S_ERR_TO;
                end
            end
            S_WAIT_ECHO: begin
                if (rx_DV) begin
                    to_clear = 1'b1;
                    if (echo_ok) begin
                        byte_cnt_d = '0;
                        state_d    = S_RECV_R;
                    end else begin
                        state_d = S_ERR_ECHO;
                    end
                end else if (to_expire) begin
                    state_d = S_ERR_TO;
                end
            end
            S_RECV_R: begin
                if (rx_DV) begin
                    to_clear   = 1'b1;
                    shift_en   = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (rx_last) begin
`ifdef PUF_SECOND_RESP_EN
                        cap_first = 1'b1;
                        state_d   = S_WAIT_ECHO2;
`else
                        load_resp = 1'b1;
                        state_d   = S_FINISH;
`endif
                    end
                end else if (to_expire) begin
                    state_d = S_ERR_TO;
                end
            end
`ifdef PUF_SECOND_RESP_EN
            S_WAIT_ECHO2: begin
                if (rx_DV) begin
                    to_clear = 1'b1;
                    if (echo_ok) begin
                        byte_cnt_d = '0;
                        state_d    = S_RECV_S;
                    end else begin
                        state_d = S_ERR_ECHO;
                    end
                end else if (to_expire) begin
                    state_d = S_ERR_TO;
                end
            end
            S_RECV_S: begin
                if (rx_DV) begin
                    to_clear   = 1'b1;
                    shift_en   = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (rx_last) begin
                        load_resp = 1'b1;
                        state_d   = S_FINISH;
                    end
                end else if (to_expire) begin
                    state_d = S_ERR_TO;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The final byte bypasses shift_q, so the word is complete on the FINISH edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            chal_q     <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            response_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            if (state_q == S_IDLE && start) chal_q <= challenge_in;
            if (shift_en) shift_q <= {shift_q[RESP_W-2*BYTE_W-1:0], rx_byte};
            if (load_resp) begin
`ifdef PUF_SECOND_RESP_EN
                response_q <= first_q;
`else
                response_q <= {shift_q, rx_byte};
`endif
            end
        end
    end

`ifdef PUF_SECOND_RESP_EN
    // The first word is parked so an error in the second frame leaves response untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_q  <= '0;
            second_q <= '0;
        end else begin
            if (cap_first) first_q <= {shift_q, rx_byte};
            if (load_resp) second_q <= {shift_q, rx_byte};
        end
    end

    assign second    = second_q;
    assign second_DV = (state_q == S_FINISH);
`else
    assign second    = '0;
    assign second_DV = 1'b0;
`endif

    assign tx_DV       = (state_q == S_SEND_CH);
    assign tx_byte     = tx_DV ? chal_q : '0;
    assign response    = response_q;
    assign response_DV = (state_q == S_FINISH);
    assign done        = (state_q == S_FINISH);
    assign busy        = (state_q != S_IDLE);
    assign err_echo    = (state_q == S_ERR_ECHO);
    assign err_timeout = (state_q == S_ERR_TO);
    assign dbg_state_o = state_q;

endmodule
